// File: rtl/playfield_tile_fetch.sv
// Playfield tile fetcher: walks the 32x30 tile map, reads char ROM, serialises 2bpp pixels.
// Optional cocktail flip when PF_FLIP_EN is defined (adds the flip input).
module playfield_tile_fetch #(
    parameter int HTOTAL  = 320,
    parameter int VTOTAL  = 262,
    parameter int VACTIVE = 240
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        pix_ce,
    input  logic [8:0]  hcount,
    input  logic [8:0]  vcount,
`ifdef PF_FLIP_EN
    input  logic        flip,
`endif
    output logic [9:0]  pf_addr,
    input  logic [7:0]  pf_data,
    output logic [8:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [1:0]  pix_color,
    output logic [1:0]  pix_pal,
    output logic        pix_valid,
    output logic        fetch_ovr
);

    localparam logic [8:0] LP_HPRE  = 9'(HTOTAL - 8);
    localparam logic [8:0] LP_VLAST = 9'(VTOTAL - 1);
    localparam logic [8:0] LP_VACT  = 9'(VACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_WAIT,
        ST_ROM_REQ,
        ST_ROM_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_pf_addr;
    logic [8:0]  r_rom_addr;
    logic [8:0]  w_rom_addr;
    logic [2:0]  r_tl;
    logic        r_fflip;
    logic [1:0]  r_fpal;

    logic [7:0]  r_nb_p1;
    logic [7:0]  r_nb_p0;
    logic [1:0]  r_nb_pal;
    logic        r_nb_flip;

    logic [7:0]  r_sh1;
    logic [7:0]  r_sh0;
    logic [1:0]  r_sh_pal;
    logic        r_sh_flip;

    logic        r_ovr;

    logic        w_flip;
    logic        w_edge;
    logic        w_vis_row;
    logic        w_in_line;
    logic        w_pre_ok;
    logic        w_trig;
    logic [8:0]  w_nline;
    logic [7:0]  w_line;
    logic [4:0]  w_col;
    logic [4:0]  w_row;
    logic [2:0]  w_tl;
    logic        w_vis;
    logic [1:0]  w_pix;

`ifdef PF_FLIP_EN
    assign w_flip = flip;
`else
    assign w_flip = 1'b0;
`endif

    // Trigger decode and target tile address (with optional flip mapping)
    always_comb begin
        w_edge    = pix_ce && (hcount[2:0] == 3'd0);
        w_vis_row = (vcount < LP_VACT);
        w_in_line = (hcount < 9'd248) && w_vis_row;
        w_nline   = (vcount == LP_VLAST) ? 9'd0 : vcount + 9'd1;
        w_pre_ok  = (hcount == LP_HPRE) && (w_nline < LP_VACT);
        w_trig    = w_edge && (w_in_line || w_pre_ok);
        w_col     = w_in_line ? hcount[7:3] + 5'd1 : 5'd0;
        w_line    = w_in_line ? vcount[7:0] : w_nline[7:0];
        w_row     = w_line[7:3];
        w_tl      = w_line[2:0];
        if (w_flip) begin
            w_col = ~w_col;
            w_row = 5'd29 - w_row;
            w_tl  = ~w_tl;
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch FSM next state; the ROM address is presented straight from
    // pf_data in ROM_REQ so the ROM's one-clock latency lands in ROM_WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_rom_addr  = r_rom_addr;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = ST_RAM_WAIT;
                end
            end
            ST_RAM_WAIT: begin
                w_state_nxt = ST_ROM_REQ;
            end
            ST_ROM_REQ: begin
                w_rom_addr  = {pf_data[5:0], r_tl};
                w_state_nxt = ST_ROM_WAIT;
            end
            ST_ROM_WAIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch datapath: address latches and the next-tile buffer
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_pf_addr  <= '0;
            r_rom_addr <= '0;
            r_tl       <= '0;
            r_fflip    <= 1'b0;
            r_fpal     <= '0;
            r_nb_p1    <= '0;
            r_nb_p0    <= '0;
            r_nb_pal   <= '0;
            r_nb_flip  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_trig) begin
                r_pf_addr <= {w_row, w_col};
                r_tl      <= w_tl;
                r_fflip   <= w_flip;
            end
            if (r_state == ST_ROM_REQ) begin
                r_fpal     <= pf_data[7:6];
                r_rom_addr <= w_rom_addr;
            end
            if (r_state == ST_ROM_WAIT) begin
                r_nb_p1   <= rom_data[15:8];
                r_nb_p0   <= rom_data[7:0];
                r_nb_pal  <= r_fpal;
                r_nb_flip <= r_fflip;
            end
        end
    end

    // Sticky overrun: a trigger while a fetch is still in flight
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ovr <= 1'b0;
        end else if (w_trig && r_state != ST_IDLE) begin
            r_ovr <= 1'b1;
        end
    end

    // Pixel shifters: load at the last pixel of a tile, else shift
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sh1     <= '0;
            r_sh0     <= '0;
            r_sh_pal  <= '0;
            r_sh_flip <= 1'b0;
        end else if (pix_ce) begin
            if (hcount[2:0] == 3'd7) begin
                r_sh1     <= r_nb_p1;
                r_sh0     <= r_nb_p0;
                r_sh_pal  <= r_nb_pal;
                r_sh_flip <= r_nb_flip;
            end else if (r_sh_flip) begin
                r_sh1 <= {1'b0, r_sh1[7:1]};
                r_sh0 <= {1'b0, r_sh0[7:1]};
            end else begin
                r_sh1 <= {r_sh1[6:0], 1'b0};
                r_sh0 <= {r_sh0[6:0], 1'b0};
            end
        end
    end

    // Visible-area decode and pixel selection; reset forces outputs low
    always_comb begin
        w_vis = !hcount[8] && w_vis_row;
        if (r_sh_flip) begin
            w_pix = {r_sh1[0], r_sh0[0]};
        end else begin
            w_pix = {r_sh1[7], r_sh0[7]};
        end
    end

    assign pix_valid = rst_l && w_vis;
    assign pix_color = pix_valid ? w_pix : 2'b00;
    assign pix_pal   = r_sh_pal;
    assign pf_addr   = r_pf_addr;
    assign rom_addr  = w_rom_addr;
    assign fetch_ovr = r_ovr;

endmodule

// File: tb/tb_playfield_tile_fetch.sv
// Directed bench for playfield_tile_fetch with synchronous RAM/ROM models.
// Build with PF_FLIP_EN defined to also exercise the flip port.
module tb_playfield_tile_fetch;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        pix_ce = 1'b0;
    logic [8:0]  hcount = '0;
    logic [8:0]  vcount = '0;
`ifdef PF_FLIP_EN
    logic        flip = 1'b0;
`endif
    logic [9:0]  pf_addr;
    logic [7:0]  pf_data;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [1:0]  pix_color;
    logic [1:0]  pix_pal;
    logic        pix_valid;
    logic        fetch_ovr;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ram [1024];
    logic [15:0] rom [512];
    logic [1:0]  exp1 [8];
    logic [1:0]  exp2 [8];

    playfield_tile_fetch dut (
        .clk(clk),
        .rst_l(rst_l),
        .pix_ce(pix_ce),
        .hcount(hcount),
        .vcount(vcount),
`ifdef PF_FLIP_EN
        .flip(flip),
`endif
        .pf_addr(pf_addr),
        .pf_data(pf_data),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .pix_color(pix_color),
        .pix_pal(pix_pal),
        .pix_valid(pix_valid),
        .fetch_ovr(fetch_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pf_data  <= ram[pf_addr];
        rom_data <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [8:0] h, input logic [8:0] v,
                         input logic ce);
        hcount = h;
        vcount = v;
        pix_ce = ce;
        #1;
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_ce = 1'b0;
        repeat (n) clk1();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
        ram[10'h046] = 8'h4A;
        rom[9'h051]  = 16'h1234;
        ram[10'h000] = 8'hC5;
        rom[9'h028]  = 16'hF0AA;
        ram[10'h001] = 8'h47;
        rom[9'h038]  = 16'h0FF0;
        exp1 = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
        exp2 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};

        // reset state (visible position, so pix_valid gating is exercised)
        rst_l = 1'b0;
        drive(0, 0, 0);
        clk1();
        clk1();
        chk("rst_pf_addr", 16'(pf_addr), 16'h000);
        chk("rst_rom_addr", 16'(rom_addr), 16'h000);
        chk("rst_color", 16'(pix_color), 16'h0);
        chk("rst_pal", 16'(pix_pal), 16'h0);
        chk("rst_valid", 16'(pix_valid), 16'h0);
        chk("rst_ovr", 16'(fetch_ovr), 16'h0);
        rst_l = 1'b1;
        #1;
        chk("valid_h0v0", 16'(pix_valid), 16'h1);

        // addressing: v17 h40 -> row2 col6, tile line 1
        drive(40, 17, 1);
        clk1();
        drive(40, 17, 0);
        chk("addr_pf", 16'(pf_addr), 16'h046);
        chk("addr_valid", 16'(pix_valid), 16'h1);
        clk1();
        chk("addr_rom_req", 16'(rom_addr), 16'h051);
        clk1();
        chk("addr_rom_hold", 16'(rom_addr), 16'h051);
        clk1();
        chk("addr_no_ovr", 16'(fetch_ovr), 16'h0);

        // line 0 prefetch from the last line of the frame
        drive(312, 261, 1);
        clk1();
        drive(312, 261, 0);
        chk("pre_pf_addr", 16'(pf_addr), 16'h000);
        chk("pre_valid", 16'(pix_valid), 16'h0);
        clk1();
        chk("pre_rom_addr", 16'(rom_addr), 16'h028);
        clk1();
        clk1();
        drive(319, 261, 1);
        clk1();

        // tile 0 of line 0: F0/AA -> 3,2,3,2,1,0,1,0 with palette 3
        for (int h = 0; h < 8; h++) begin
            drive(9'(h), 0, 1);
            if (h == 0) chk("t0_pal", 16'(pix_pal), 16'h3);
            chk($sformatf("t0_px%0d", h), 16'(pix_color), 16'(exp1[h]));
            clk1();
        end
        // tile 1 fetched during tile 0: 0F/F0 -> 1,1,1,1,2,2,2,2 palette 1
        for (int h = 8; h < 16; h++) begin
            drive(9'(h), 0, 1);
            if (h == 8) chk("t1_pal", 16'(pix_pal), 16'h1);
            chk($sformatf("t1_px%0d", h), 16'(pix_color), 16'(exp2[h - 8]));
            clk1();
        end
        pix_ce = 1'b0;
        chk("t2_pf_addr", 16'(pf_addr), 16'h002);

        // blanking
        drive(256, 0, 0);
        chk("hblank_valid", 16'(pix_valid), 16'h0);
        chk("hblank_color", 16'(pix_color), 16'h0);
        drive(264, 0, 1);
        clk1();
        drive(264, 0, 0);
        chk("hblank_no_fetch", 16'(pf_addr), 16'h002);
        idle(4);
        drive(16, 240, 1);
        clk1();
        drive(16, 240, 0);
        chk("vblank_no_fetch", 16'(pf_addr), 16'h002);
        chk("vblank_valid", 16'(pix_valid), 16'h0);
        chk("vblank_color", 16'(pix_color), 16'h0);
        idle(4);

        // prefetch for last visible line 239, then suppressed for 240
        drive(312, 238, 1);
        clk1();
        drive(312, 238, 0);
        chk("pre239_pf", 16'(pf_addr), 16'h3A0);
        idle(4);
        chk("pre239_rom", 16'(rom_addr), 16'h007);
        drive(312, 239, 1);
        clk1();
        drive(312, 239, 0);
        chk("pre240_sup_pf", 16'(pf_addr), 16'h3A0);
        idle(4);
        chk("pre240_sup_rom", 16'(rom_addr), 16'h007);
        chk("pre240_no_ovr", 16'(fetch_ovr), 16'h0);

        // overrun: second trigger two clocks after the first
        drive(0, 5, 1);
        clk1();
        drive(0, 5, 0);
        clk1();
        drive(16, 5, 1);
        clk1();
        drive(16, 5, 0);
        chk("ovr_set", 16'(fetch_ovr), 16'h1);
        chk("ovr_ignored", 16'(pf_addr), 16'h001);
        idle(10);
        chk("ovr_sticky", 16'(fetch_ovr), 16'h1);

        // reset during ROM_WAIT
        drive(0, 0, 1);
        clk1();
        drive(0, 0, 0);
        clk1();
        clk1();
        rst_l = 1'b0;
        #1;
        chk("mid_rst_pf", 16'(pf_addr), 16'h000);
        chk("mid_rst_rom", 16'(rom_addr), 16'h000);
        chk("mid_rst_color", 16'(pix_color), 16'h0);
        chk("mid_rst_pal", 16'(pix_pal), 16'h0);
        chk("mid_rst_valid", 16'(pix_valid), 16'h0);
        chk("mid_rst_ovr", 16'(fetch_ovr), 16'h0);
        clk1();
        rst_l = 1'b1;
        idle(6);
        chk("post_rst_pf", 16'(pf_addr), 16'h000);
        chk("post_rst_rom", 16'(rom_addr), 16'h000);
        drive(7, 0, 1);
        clk1();
        drive(8, 0, 0);
        chk("post_rst_buf_pal", 16'(pix_pal), 16'h0);
        chk("post_rst_buf_color", 16'(pix_color), 16'h0);
        drive(40, 17, 1);
        clk1();
        drive(40, 17, 0);
        chk("post_rst_fetch", 16'(pf_addr), 16'h046);
        idle(4);

`ifdef PF_FLIP_EN
        // flipped line 0 col 0 -> row 29 col 31
        flip = 1'b1;
        drive(312, 261, 1);
        clk1();
        drive(312, 261, 0);
        chk("flip_pf_addr", 16'(pf_addr), 16'h3BF);
        idle(4);
        flip = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
